// File: rtl/lsu_handshake_if.sv
// Bundle between the MEM-stage pipeline, the load/store unit and the data-memory port.
//
// Handshake rule for both request channels (req_* and mm_req_*): a transfer happens on
// the rising clock edge where valid and ready are both 1. Once the producer raises valid,
// it keeps valid and the payload stable until that edge. The consumer may hold ready
// at 0 for any number of cycles. resp_valid and mm_rvalid are single-cycle pulses with
// no back-pressure.
interface lsu_handshake_if #(
  parameter int XLEN = 64
);
  localparam int NB = XLEN / 8;

  // Pipeline-side request and response
  logic            req_valid;
  logic            req_ready;
  logic            load_en;
  logic            store_en;
  logic [2:0]      funct3;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] store_data;
  logic            resp_valid;
  logic [XLEN-1:0] load_data;
  logic            resp_exc;

  // Data-memory port
  logic            mm_req_valid;
  logic            mm_req_ready;
  logic [XLEN-1:0] mm_addr;
  logic            mm_wen;
  logic [XLEN-1:0] mm_wdata;
  logic [NB-1:0]   mm_wstrb;
  logic            mm_rvalid;
  logic [XLEN-1:0] mm_rdata;

  // Current FSM state of the LSU, for observation only
  logic [1:0]      dbg_state;

  // LSU side
  modport slave (
    input  req_valid, load_en, store_en, funct3, address, store_data,
    input  mm_req_ready, mm_rvalid, mm_rdata,
    output req_ready, resp_valid, load_data, resp_exc,
    output mm_req_valid, mm_addr, mm_wen, mm_wdata, mm_wstrb,
    output dbg_state
  );

  // Pipeline and memory side
  modport master (
    output req_valid, load_en, store_en, funct3, address, store_data,
    output mm_req_ready, mm_rvalid, mm_rdata,
    input  req_ready, resp_valid, load_data, resp_exc,
    input  mm_req_valid, mm_addr, mm_wen, mm_wdata, mm_wstrb,
    input  dbg_state
  );
endinterface

// File: rtl/lsu_handshake.sv
// Load/store unit for the MEM stage: valid/ready request to the data bus, byte-lane
// alignment with write strobes, response wait, funct3 legality check.
// FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE (REQ -> RESP when the read data or write
// acknowledge arrives in the same cycle as the request handshake; IDLE -> RESP for
// operations that are rejected).
// Optional build macro LSU_MISALIGN_TRAP_EN: accesses whose address is not aligned to
// their size are rejected with resp_exc instead of being issued. Without the macro, no
// alignment check is made and strobe/data lanes shifted past the word are dropped.
module lsu_handshake #(
  parameter int XLEN  = 64,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input logic            clk,
  input logic            rst,
  lsu_handshake_if.slave bus
);
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             mm_req_valid_q, mm_req_valid_d;
  logic [XLEN-1:0]  mm_addr_q, mm_addr_d;
  logic             mm_wen_q, mm_wen_d;
  logic [XLEN-1:0]  mm_wdata_q, mm_wdata_d;
  logic [NB-1:0]    mm_wstrb_q, mm_wstrb_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_exc_q, resp_exc_d;
  logic [XLEN-1:0]  load_data_q, load_data_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [OFF_W-1:0] off_q, off_d;

  logic [OFF_W-1:0] req_off;
  logic [3:0]       req_size;
  logic             req_illegal;
  logic             req_misalign;
  logic [NB-1:0]    req_ones;
  logic [NB-1:0]    req_strb;
  logic [XLEN-1:0]  rd_shifted;
  logic [XLEN-1:0]  rd_ext;

  assign req_off  = bus.address[OFF_W-1:0];
  assign req_size = 4'd1 << bus.funct3[1:0];

  // Decode the offered op: legality, alignment and the byte strobes it would use
  always_comb begin
    if (bus.store_en) req_illegal = bus.funct3[2];
    else              req_illegal = (bus.funct3 == 3'b111);
    if ((XLEN == 32) && ((bus.funct3 == 3'b011) || (bus.funct3 == 3'b110)))
      req_illegal = 1'b1;

    req_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.funct3[1:0])
      2'b01:   req_misalign = bus.address[0];
      2'b10:   req_misalign = |bus.address[1:0];
      2'b11:   req_misalign = |bus.address[2:0];
      default: req_misalign = 1'b0;
    endcase
`endif

    for (int i = 0; i < NB; i++) req_ones[i] = (i < int'(req_size));
    req_strb = req_ones << req_off;
  end

  // Pick the addressed bytes out of the returned word and extend them to XLEN
  always_comb begin
    rd_shifted = bus.mm_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_ext = XLEN'($signed(rd_shifted[7:0]));
      3'b001:  rd_ext = XLEN'($signed(rd_shifted[15:0]));
      3'b010:  rd_ext = XLEN'($signed(rd_shifted[31:0]));
      3'b011:  rd_ext = rd_shifted;
      3'b100:  rd_ext = XLEN'(rd_shifted[7:0]);
      3'b101:  rd_ext = XLEN'(rd_shifted[15:0]);
      3'b110:  rd_ext = XLEN'(rd_shifted[31:0]);
      default: rd_ext = '0;
    endcase
  end

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_d        = state_q;
    req_ready_d    = req_ready_q;
    mm_req_valid_d = mm_req_valid_q;
    mm_addr_d      = mm_addr_q;
    mm_wen_d       = mm_wen_q;
    mm_wdata_d     = mm_wdata_q;
    mm_wstrb_d     = mm_wstrb_q;
    resp_valid_d   = resp_valid_q;
    resp_exc_d     = resp_exc_q;
    load_data_d    = load_data_q;
    is_store_d     = is_store_q;
    funct3_d       = funct3_q;
    off_d          = off_q;

    case (state_q)
      S_IDLE: begin
        // A request with neither enable set is not an op and gets no response
        if (bus.req_valid && (bus.load_en || bus.store_en)) begin
          req_ready_d = 1'b0;
          is_store_d  = bus.store_en;
          funct3_d    = bus.funct3;
          off_d       = req_off;
          if (req_illegal || req_misalign) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_exc_d   = 1'b1;
            load_data_d  = '0;
          end else begin
            state_d        = S_REQ;
            mm_req_valid_d = 1'b1;
            mm_addr_d      = {bus.address[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            mm_wen_d       = bus.store_en;
            mm_wdata_d     = bus.store_data << {req_off, 3'b000};
            mm_wstrb_d     = bus.store_en ? req_strb : '0;
          end
        end
      end
      S_REQ: begin
        if (bus.mm_req_ready) begin
          mm_req_valid_d = 1'b0;
          if (bus.mm_rvalid) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_exc_d   = 1'b0;
            load_data_d  = is_store_q ? '0 : rd_ext;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mm_rvalid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_exc_d   = 1'b0;
          load_data_d  = is_store_q ? '0 : rd_ext;
        end
      end
      S_RESP: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        resp_exc_d   = 1'b0;
        req_ready_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_ready_q    <= 1'b1;
      mm_req_valid_q <= 1'b0;
      mm_addr_q      <= '0;
      mm_wen_q       <= 1'b0;
      mm_wdata_q     <= '0;
      mm_wstrb_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_exc_q     <= 1'b0;
      load_data_q    <= '0;
      is_store_q     <= 1'b0;
      funct3_q       <= 3'b000;
      off_q          <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      mm_req_valid_q <= mm_req_valid_d;
      mm_addr_q      <= mm_addr_d;
      mm_wen_q       <= mm_wen_d;
      mm_wdata_q     <= mm_wdata_d;
      mm_wstrb_q     <= mm_wstrb_d;
      resp_valid_q   <= resp_valid_d;
      resp_exc_q     <= resp_exc_d;
      load_data_q    <= load_data_d;
      is_store_q     <= is_store_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.mm_req_valid = mm_req_valid_q;
  assign bus.mm_addr      = mm_addr_q;
  assign bus.mm_wen       = mm_wen_q;
  assign bus.mm_wdata     = mm_wdata_q;
  assign bus.mm_wstrb     = mm_wstrb_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_exc     = resp_exc_q;
  assign bus.load_data    = load_data_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_lsu_handshake.sv
// Bench for lsu_handshake (XLEN=64). Expected {resp_exc, load_data} values are queued
// when an op is driven and checked by the response monitor on each resp_valid pulse.
module tb_lsu_handshake;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_handshake_if #(.XLEN(64)) bus_if();
  lsu_handshake #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  // Response monitor / scoreboard
  always @(negedge clk) begin
    logic [64:0] exp;
    if (!rst && bus_if.resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got resp_valid with exc=%0b data=%h, expected none",
                 bus_if.resp_exc, bus_if.load_data);
      end else begin
        exp = exp_q.pop_front();
        if ({bus_if.resp_exc, bus_if.load_data} !== exp) begin
          errors++;
          $display("FAIL resp_data: got exc=%0b data=%h, expected exc=%0b data=%h",
                   bus_if.resp_exc, bus_if.load_data, exp[64], exp[63:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference result of one op: {exc, load_data}
  function automatic logic [64:0] model(input logic st, input logic [2:0] f3,
                                        input logic [63:0] a, input logic [63:0] rd);
    logic [63:0] s;
    logic ill, mis;
    ill = st ? f3[2] : (f3 == 3'b111);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'b01) mis = a[0];
    if (f3[1:0] == 2'b10) mis = (a[1:0] != 2'b00);
    if (f3[1:0] == 2'b11) mis = (a[2:0] != 3'b000);
`endif
    if (ill || mis) return {1'b1, 64'h0};
    if (st) return 65'h0;
    s = rd >> (8 * a[2:0]);
    case (f3)
      3'b000:  return {1'b0, {56{s[7]}}, s[7:0]};
      3'b001:  return {1'b0, {48{s[15]}}, s[15:0]};
      3'b010:  return {1'b0, {32{s[31]}}, s[31:0]};
      3'b011:  return {1'b0, s};
      3'b100:  return {1'b0, 56'h0, s[7:0]};
      3'b101:  return {1'b0, 48'h0, s[15:0]};
      default: return {1'b0, 32'h0, s[31:0]};
    endcase
  endfunction

  // Drives one op and plays the memory: holds mm_req_ready low for rdy_wait cycles of
  // mm_req_valid, then returns mm_rvalid rv_gap cycles after the handshake (0 = same
  // cycle). lat = cycles from the accept edge to resp_valid, -1 on timeout.
  task automatic drive_op(input logic st, input logic ld, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] d, input logic [63:0] rd,
                          input int rdy_wait, input int rv_gap, output int lat,
                          output logic [63:0] s_addr, output logic [7:0] s_strb,
                          output logic [63:0] s_wdata, output logic s_wen,
                          output logic unstable, output logic saw_req);
    int cyc, stall, g, phase;
    lat = -1; s_addr = '0; s_strb = '0; s_wdata = '0; s_wen = 1'b0;
    unstable = 1'b0; saw_req = 1'b0; stall = 0; g = 0; phase = 0;
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.store_en = st; bus_if.load_en = ld;
    bus_if.funct3 = f3; bus_if.address = a; bus_if.store_data = d;
    bus_if.mm_req_ready = 1'b0; bus_if.mm_rvalid = 1'b0;
    @(negedge clk);
    bus_if.req_valid = 1'b0; bus_if.store_en = 1'b0; bus_if.load_en = 1'b0;
    cyc = 1;
    while (cyc <= 64) begin
      bus_if.mm_rvalid = 1'b0; bus_if.mm_req_ready = 1'b0; bus_if.mm_rdata = ~rd;
      if (bus_if.resp_valid) begin
        lat = cyc;
        break;
      end
      if (phase == 0 && bus_if.mm_req_valid) begin
        if (!saw_req) begin
          saw_req = 1'b1; s_addr = bus_if.mm_addr; s_strb = bus_if.mm_wstrb;
          s_wdata = bus_if.mm_wdata; s_wen = bus_if.mm_wen;
        end else if (bus_if.mm_addr !== s_addr || bus_if.mm_wstrb !== s_strb ||
                     bus_if.mm_wdata !== s_wdata || bus_if.mm_wen !== s_wen) begin
          unstable = 1'b1;
        end
        if (bus_if.req_ready !== 1'b0) unstable = 1'b1;
        if (stall == rdy_wait) begin
          bus_if.mm_req_ready = 1'b1;
          if (rv_gap == 0) begin
            bus_if.mm_rvalid = 1'b1; bus_if.mm_rdata = rd; phase = 2;
          end else phase = 1;
        end else stall++;
      end else if (phase == 1) begin
        g++;
        if (g == rv_gap) begin
          bus_if.mm_rvalid = 1'b1; bus_if.mm_rdata = rd; phase = 2;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus_if.mm_rvalid = 1'b0; bus_if.mm_req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %0b expected 1", bus_if.req_ready);
    end
    checks++;
    if ({bus_if.resp_valid, bus_if.resp_exc, bus_if.mm_req_valid, bus_if.mm_wen, bus_if.mm_wstrb,
         bus_if.mm_addr, bus_if.mm_wdata, bus_if.load_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%0b exc=%0b mrv=%0b wen=%0b strb=%h addr=%h wdata=%h ld=%h, expected all 0",
               bus_if.resp_valid, bus_if.resp_exc, bus_if.mm_req_valid, bus_if.mm_wen,
               bus_if.mm_wstrb, bus_if.mm_addr, bus_if.mm_wdata, bus_if.load_data);
    end
    checks++;
    if (bus_if.dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", bus_if.dbg_state);
    end
  endtask

  task automatic test_store_dword();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
    exp_q.push_back(65'h0);
    drive_op(1, 0, 3'b011, 64'h1000, 64'h1122334455667788, 64'h0, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if (ss !== 8'hFF) begin errors++; $display("FAIL sd_strb: got %h expected ff", ss); end
    checks++;
    if (sa !== 64'h1000) begin errors++; $display("FAIL sd_addr: got %h expected 1000", sa); end
    checks++;
    if ({wen, sw} !== {1'b1, 64'h1122334455667788}) begin
      errors++; $display("FAIL sd_wdata: got wen=%0b %h expected wen=1 1122334455667788", wen, sw);
    end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL sd_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_load_byte();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
    exp_q.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FF80});
    drive_op(0, 1, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({sa, ss, wen} !== {64'h1000, 8'h00, 1'b0}) begin
      errors++; $display("FAIL lb_bus: got addr=%h strb=%h wen=%0b expected 1000 00 0", sa, ss, wen);
    end
    exp_q.push_back({1'b0, 64'h80});
    drive_op(0, 1, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL lbu_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_store_half();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
    exp_q.push_back(65'h0);
    drive_op(1, 0, 3'b001, 64'h2006, 64'hABCD, 64'h0, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if (ss !== 8'hC0) begin errors++; $display("FAIL sh_strb: got %h expected c0", ss); end
    checks++;
    if (sw[63:48] !== 16'hABCD) begin errors++; $display("FAIL sh_wdata: got %h expected abcd", sw[63:48]); end
    checks++;
    if (sa !== 64'h2000) begin errors++; $display("FAIL sh_addr: got %h expected 2000", sa); end
  endtask

  task automatic test_ready_stall();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
    exp_q.push_back({1'b0, 64'hFFFF_FFFF_DEAD_BEEF});
    drive_op(0, 1, 3'b010, 64'h3000, 64'h0, 64'h0000_0000_DEAD_BEEF, 5, 2, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({sr, un} !== 2'b10) begin
      errors++; $display("FAIL stall_stable: got saw_req=%0b unstable=%0b expected 1 0", sr, un);
    end
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL stall_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_same_cycle_rvalid();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
    exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    drive_op(0, 1, 3'b011, 64'h4008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL same_cycle_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_illegal();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
    exp_q.push_back({1'b1, 64'h0});
    drive_op(1, 0, 3'b100, 64'h1000, 64'h55, 64'h0, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({sr, lat} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL illegal_store: got saw_req=%0b lat=%0d expected 0 1", sr, lat);
    end
    exp_q.push_back({1'b1, 64'h0});
    drive_op(0, 1, 3'b111, 64'h1000, 64'h0, 64'hFFFF, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({sr, lat} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL illegal_load: got saw_req=%0b lat=%0d expected 0 1", sr, lat);
    end
    // Both enables set: the store wins
    exp_q.push_back(65'h0);
    drive_op(1, 1, 3'b010, 64'h5004, 64'h1234_5678, 64'h0, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({wen, ss} !== {1'b1, 8'hF0}) begin
      errors++; $display("FAIL store_wins: got wen=%0b strb=%h expected 1 f0", wen, ss);
    end
  endtask

  task automatic test_misalign();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_q.push_back({1'b1, 64'h0});
    drive_op(0, 1, 3'b010, 64'h1002, 64'h0, 64'h1122_3344_5566_7788, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({sr, lat} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL misalign_lw: got saw_req=%0b lat=%0d expected 0 1", sr, lat);
    end
    exp_q.push_back({1'b1, 64'h0});
    drive_op(1, 0, 3'b010, 64'h1006, 64'hAABB_CCDD, 64'h0, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({sr, lat} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL misalign_sw: got saw_req=%0b lat=%0d expected 0 1", sr, lat);
    end
`else
    exp_q.push_back({1'b0, 64'h3344_5566});
    drive_op(0, 1, 3'b010, 64'h1002, 64'h0, 64'h1122_3344_5566_7788, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({sa, lat} !== {64'h1000, 32'd3}) begin
      errors++; $display("FAIL misalign_lw: got addr=%h lat=%0d expected 1000 3", sa, lat);
    end
    exp_q.push_back(65'h0);
    drive_op(1, 0, 3'b010, 64'h1006, 64'hAABB_CCDD, 64'h0, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if ({ss, sw} !== {8'hC0, 64'hCCDD_0000_0000_0000}) begin
      errors++; $display("FAIL misalign_sw: got strb=%h wdata=%h expected c0 ccdd000000000000", ss, sw);
    end
`endif
  endtask

  task automatic test_ignored();
    logic bad = 1'b0;
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.load_en = 1'b0; bus_if.store_en = 1'b0;
    bus_if.mm_rvalid = 1'b1; bus_if.mm_rdata = 64'hFFFF;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.mm_req_valid !== 1'b0 || bus_if.req_ready !== 1'b1) bad = 1'b1;
    end
    bus_if.req_valid = 1'b0; bus_if.mm_rvalid = 1'b0;
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL ignored_req: got activity=1 expected 0"); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [63:0] sa, sw; logic [7:0] ss; logic wen, un, sr;
    logic bad = 1'b0;
    @(negedge clk);
    bus_if.req_valid = 1'b1; bus_if.load_en = 1'b1; bus_if.funct3 = 3'b011; bus_if.address = 64'h6000;
    @(negedge clk);
    bus_if.req_valid = 1'b0; bus_if.load_en = 1'b0; bus_if.mm_req_ready = 1'b1;
    @(negedge clk);
    bus_if.mm_req_ready = 1'b0;
    checks++;
    if (bus_if.dbg_state !== 2'd2) begin
      errors++; $display("FAIL rst_wait_state: got %0d expected 2", bus_if.dbg_state);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.req_ready, bus_if.resp_valid, bus_if.resp_exc, bus_if.mm_req_valid, bus_if.mm_wen,
         bus_if.mm_wstrb, bus_if.mm_addr, bus_if.mm_wdata, bus_if.load_data} !== {1'b1, 204'h0}) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ready=%0b mrv=%0b addr=%h ld=%h expected ready=1 rest 0",
               bus_if.req_ready, bus_if.mm_req_valid, bus_if.mm_addr, bus_if.load_data);
    end
    bus_if.mm_rvalid = 1'b1; bus_if.mm_rdata = 64'h1234;
    @(negedge clk);
    bus_if.mm_rvalid = 1'b0;
    repeat (3) begin
      if (bus_if.resp_valid !== 1'b0 || bus_if.dbg_state !== 2'd0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rst_drop_resp: got activity=1 expected 0"); end
    exp_q.push_back({1'b0, 64'h0BAD_CAFE_1234_5678});
    drive_op(0, 1, 3'b011, 64'h6000, 64'h0, 64'h0BAD_CAFE_1234_5678, 0, 1, lat, sa, ss, sw, wen, un, sr);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL rst_next_op: got lat=%0d expected 3", lat); end
  endtask

  task automatic test_random();
    int lat, rw, gp, exp_lat; logic [63:0] sa, sw, a, d, rd; logic [7:0] ss; logic wen, un, sr, st;
    logic [2:0] f3; logic [64:0] e; logic [15:0] m;
    for (int i = 0; i < 24; i++) begin
      st = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      a = {32'h0, 16'h0, 4'($urandom_range(1, 15)), 9'($urandom_range(0, 511)), 3'($urandom_range(0, 7))};
      d = {$urandom(), $urandom()}; rd = {$urandom(), $urandom()};
      rw = $urandom_range(0, 3); gp = $urandom_range(0, 3);
      e = model(st, f3, a, rd);
      exp_q.push_back(e);
      drive_op(st, !st, f3, a, d, rd, rw, gp, lat, sa, ss, sw, wen, un, sr);
      exp_lat = e[64] ? 1 : 2 + rw + gp;
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      if (!e[64]) begin
        m = (16'd1 << (1 << f3[1:0])) - 16'd1;
        m = st ? (m << a[2:0]) : 16'h0;
        checks++;
        if ({sa, ss, wen} !== {a & ~64'h7, m[7:0], st}) begin
          errors++; $display("FAIL rand_bus[%0d]: got addr=%h strb=%h wen=%0b expected %h %h %0b",
                             i, sa, ss, wen, a & ~64'h7, m[7:0], st);
        end
        if (st) begin
          checks++;
          if (sw !== (d << (8 * a[2:0]))) begin
            errors++; $display("FAIL rand_wdata[%0d]: got %h expected %h", i, sw, d << (8 * a[2:0]));
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_if.req_valid = 1'b0; bus_if.load_en = 1'b0; bus_if.store_en = 1'b0;
    bus_if.funct3 = 3'b000; bus_if.address = '0; bus_if.store_data = '0;
    bus_if.mm_req_ready = 1'b0; bus_if.mm_rvalid = 1'b0; bus_if.mm_rdata = '0;
    test_reset();
    test_store_dword();
    test_load_byte();
    test_store_half();
    test_ready_stall();
    test_same_cycle_rvalid();
    test_illegal();
    test_misalign();
    test_ignored();
    test_reset_mid_wait();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_expected: got %0d pending responses expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
